fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer for the RV32 Harvard pipeline. Owns the program counter and drives the address of the combinational instruction ROM. Captures the returned word into the IF/ID register and hands it to decode under a valid/ready handshake. Also handles branch/jump redirects with flush, halts on EBREAK or a fetch fault, and counts retired fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- IMEM_WORDS, 32, ROM depth in words; legal fetch word index is 0..IMEM_WORDS-1.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- o_imem_addr  out  32  byte address to the instruction ROM; equals the PC register.
- i_imem_instr  in  32  ROM read data, valid in the same cycle as o_imem_addr.
- i_id_ready  in  1  decode accepts o_if_* this cycle.
- i_redirect  in  1  branch/jump taken; flush and refetch.
- i_redirect_pc  in  32  redirect target byte address.
- o_if_valid  out  1  IF/ID register holds an instruction.
- o_if_pc  out  32  PC of the held instruction.
- o_if_instr  out  32  held instruction word.
- o_halted  out  1  fetch stopped (state HALT).
- o_fault  out  1  sticky fetch fault (misaligned redirect or out-of-range PC).
- o_fetch_count  out  32  number of handshakes completed (o_if_valid & i_id_ready); wraps at 2^32.

## Operation
- States: START, RUN, HALT. Reset drives START.
- Reset values:
  - pc = RESET_PC.
  - o_if_valid = 0; o_if_pc = 0; o_if_instr = 0.
  - o_halted = 0; o_fault = 0; o_fetch_count = 0.
- START: unconditional move to RUN on the first edge after reset release. No fetch is loaded in this cycle.
- Load condition, in RUN: `load = !o_if_valid || i_id_ready`.
- Priority per edge, highest first:
  1. **Redirect.** i_redirect=1 in RUN or HALT:
     - o_if_valid <= 0 (flush the held instruction, even if i_id_ready=1; a flushed instruction still counts if i_id_ready=1 that cycle).
     - If i_redirect_pc[1:0] != 0: o_fault <= 1, state <= HALT, pc unchanged.
     - Otherwise pc <= i_redirect_pc and state <= RUN (a redirect leaves HALT unless o_fault=1).
  2. **Fault.** In RUN with load=1 and pc[31:2] >= IMEM_WORDS:
     - Nothing is loaded; o_if_valid <= 0.
     - o_fault <= 1; state <= HALT.
  3. **Fetch.** In RUN with load=1:
     - o_if_pc <= pc; o_if_instr <= i_imem_instr; o_if_valid <= 1; pc <= pc + 4 (32-bit wrap).
     - If i_imem_instr == 32'h0010_0073 (EBREAK), also state <= HALT. The EBREAK itself is delivered.
  4. **Stall.** In RUN with load=0: hold pc and the IF/ID register.
- HALT:
  - No new loads.
  - A held instruction stays valid until accepted, then o_if_valid <= 0.
  - o_halted = (state == HALT).
- o_fault is sticky until reset. Once o_fault=1, redirects still flush but never leave HALT.
- o_fetch_count increments on every edge where o_if_valid & i_id_ready, regardless of state.
- Async reset mid-operation: all state and outputs return to reset values immediately. The in-flight instruction is dropped.

## Timing
- o_imem_addr is combinational from the pc register; the ROM has zero latency.
- Reset release before edge E0:
  - E0: START -> RUN.
  - E1: o_if_valid=1 with o_if_pc=RESET_PC.
- Steady state: one instruction per cycle while i_id_ready=1.
- Redirect latency:
  - Redirect sampled at edge N: pc=target after N.
  - Target instruction valid after N+1. One bubble.
- Stall: o_if_* stable while o_if_valid=1 and i_id_ready=0.
- EBREAK: loaded at edge N; o_halted=1 after N; o_if_valid falls on the edge that accepts it.

## Test plan
- **Reset/stream.** ROM words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193; i_id_ready=1.
  - Expect o_if_pc 0x0, 0x4, 0x8, 0xC on consecutive cycles starting at E1, with matching instrs.
  - o_fetch_count=4 after 4 accepts.
- **Stall.** Hold i_id_ready=0 for 3 cycles while o_if_pc=0x4.
  - o_if_pc/o_if_instr stay 0x4/0x00100093; o_imem_addr stays 0x8; count unchanged.
  - Resume gives 0x8 next.
- **Redirect.** Pulse i_redirect=1, i_redirect_pc=0x40 while o_if_pc=0x8.
  - Next cycle: o_if_valid=0, o_imem_addr=0x40.
  - Following cycle: o_if_pc=0x40.
- **EBREAK.** ROM word 5 = 0x00100073.
  - o_if_pc=0x14 delivered, o_halted=1, o_imem_addr=0x18 frozen.
  - o_if_valid drops after accept; no further loads.
  - A later redirect to 0x0 resumes at 0x0 with o_halted=0.
- **Faults.**
  - Redirect to 0x42: o_fault=1, o_halted=1, o_if_valid=0.
  - Separately, sequential fetch reaching pc=0x80 (IMEM_WORDS=32): o_fault=1, nothing loaded for 0x80.
  - Both cases: a subsequent redirect to 0x0 keeps o_halted=1.
- **Async reset mid-stream.** Assert i_rst_n=0 between edges while o_if_valid=1.
  - All outputs go to reset values immediately; o_fetch_count=0.
  - Refetch starts at RESET_PC on E1 after release.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads a zero-latency ROM, and fills the IF/ID register.
// Latency: first fetch valid on the second edge after reset release; one instruction per cycle after that; one bubble after a redirect.
// Backpressure: i_id_ready=0 holds the IF/ID register and the PC; a redirect flushes regardless of i_id_ready.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   o_imem_addr / i_imem_instr      ROM byte address (the PC) and its same-cycle read data
//   o_if_valid/o_if_pc/o_if_instr   IF/ID register, handed to decode when i_id_ready=1
//   i_id_ready                      decode accepts the IF/ID register this cycle
//   i_redirect, i_redirect_pc       taken branch/jump: flush and refetch from the target
//   o_halted                        fetch stopped (EBREAK, fault)
//   o_fault                         sticky: misaligned redirect or PC past the end of the ROM
//   o_fetch_count                   completed IF/ID handshakes, wraps at 2^32

module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  input  logic        i_id_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic        o_halted,
  output logic        o_fault,
  output logic [31:0] o_fetch_count
);

  localparam logic [31:0] EBREAK     = 32'h0010_0073;
  // One extra bit so the word-index comparison cannot overflow for any IMEM_WORDS.
  localparam logic [30:0] WORD_LIMIT = 31'(IMEM_WORDS);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic        valid_q,    valid_d;
  logic [31:0] if_pc_q,    if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        fault_q,    fault_d;
  logic [31:0] count_q,    count_d;

  logic        accept;
  logic        load;
  logic        pc_out_of_range;
  logic        redirect_misaligned;

  // A handshake completes whenever something is held and decode takes it,
  // even on the edge where a redirect flushes that same instruction.
  assign accept              = valid_q & i_id_ready;
  assign load                = ~valid_q | i_id_ready;
  assign pc_out_of_range     = {1'b0, pc_q[31:2]} >= WORD_LIMIT;
  assign redirect_misaligned = i_redirect_pc[1:0] != 2'b00;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= START;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      fault_q    <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    fault_d    = fault_q;
    count_d    = accept ? count_q + 32'd1 : count_q;

    unique case (state_q)
      START: begin
        // Give the ROM one cycle to present the reset-PC word.
        state_d = RUN;
      end

      RUN, HALT: begin
        if (i_redirect) begin
          valid_d = 1'b0;
          if (redirect_misaligned) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = i_redirect_pc;
            // A fault is terminal: redirects still flush but never restart fetch.
            state_d = fault_q ? HALT : RUN;
          end
        end else if (state_q == RUN) begin
          if (load) begin
            if (pc_out_of_range) begin
              valid_d = 1'b0;
              fault_d = 1'b1;
              state_d = HALT;
            end else begin
              if_pc_d    = pc_q;
              if_instr_d = i_imem_instr;
              valid_d    = 1'b1;
              pc_d       = pc_q + 32'd4;
              // EBREAK is still delivered to decode; only further fetches stop.
              if (i_imem_instr == EBREAK) begin
                state_d = HALT;
              end
            end
          end
        end else begin
          // HALT drains whatever is held, then sits empty.
          if (accept) begin
            valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = START;
      end
    endcase
  end

  assign o_imem_addr   = pc_q;
  assign o_if_valid    = valid_q;
  assign o_if_pc       = if_pc_q;
  assign o_if_instr    = if_instr_q;
  assign o_halted      = state_q == HALT;
  assign o_fault       = fault_q;
  assign o_fetch_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed vector table, hand-written corner sequences,
// and a randomized run compared cycle by cycle against a behavioural model.
module tb_fetch_controller;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_instr;
  logic        i_id_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        o_halted;
  logic        o_fault;
  logic [31:0] o_fetch_count;

  logic [31:0] rom [32];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ifpc, m_instr, m_count;
  logic        m_valid, m_halt, m_fault, m_started;

  fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_addr   (o_imem_addr),
    .i_imem_instr  (i_imem_instr),
    .i_id_ready    (i_id_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_if_valid    (o_if_valid),
    .o_if_pc       (o_if_pc),
    .o_if_instr    (o_if_instr),
    .o_halted      (o_halted),
    .o_fault       (o_fault),
    .o_fetch_count (o_fetch_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Zero-latency ROM; reads past the end return a recognisable junk word.
  always_comb begin
    if (o_imem_addr[31:7] == 25'd0) i_imem_instr = rom[o_imem_addr[6:2]];
    else                            i_imem_instr = 32'hDEAD_BEEF;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0; m_started = 1'b0;
  endtask

  // One rising edge of the specified behaviour, evaluated on pre-edge state.
  task automatic model_edge(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic taken;
    taken = m_valid && rdy;
    if (taken) m_count = m_count + 1;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (redir) begin
      m_valid = 1'b0;
      if (rpc % 4 != 0) begin
        m_fault = 1'b1;
        m_halt  = 1'b1;
      end else begin
        m_pc   = rpc;
        m_halt = m_fault;
      end
    end else if (!m_halt) begin
      if (!m_valid || rdy) begin
        if (m_pc / 4 >= 32) begin
          m_valid = 1'b0;
          m_fault = 1'b1;
          m_halt  = 1'b1;
        end else begin
          m_ifpc  = m_pc;
          m_instr = rom[m_pc / 4];
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
          if (m_instr == EBREAK) m_halt = 1'b1;
        end
      end
    end else if (taken) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cmp_all();
    chk("m.if_valid", {31'b0, o_if_valid}, {31'b0, m_valid});
    chk("m.if_pc",    o_if_pc,       m_ifpc);
    chk("m.if_instr", o_if_instr,    m_instr);
    chk("m.imem_addr", o_imem_addr,  m_pc);
    chk("m.halted",   {31'b0, o_halted}, {31'b0, m_halt});
    chk("m.fault",    {31'b0, o_fault},  {31'b0, m_fault});
    chk("m.count",    o_fetch_count, m_count);
  endtask

  // Drive inputs away from the edge, clock once, check 1 time unit after the edge.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    i_id_ready    = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    model_edge(rdy, redir, rpc);
    @(posedge i_clk);
    #1;
    cmp_all();
  endtask

  // Called 1 time unit after an edge: asserts reset between edges, checks the
  // immediate effect, then releases just after the following edge.
  task automatic do_reset();
    i_rst_n    = 1'b0;
    i_redirect = 1'b0;
    model_reset();
    #2;
    chk("rst.if_valid", {31'b0, o_if_valid}, 32'd0);
    chk("rst.if_pc",    o_if_pc,    32'h0);
    chk("rst.if_instr", o_if_instr, 32'h0);
    chk("rst.imem_addr", o_imem_addr, 32'h0);
    chk("rst.halted",   {31'b0, o_halted}, 32'd0);
    chk("rst.fault",    {31'b0, o_fault},  32'd0);
    chk("rst.count",    o_fetch_count, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_ifpc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vt [10];

  initial begin
    i_rst_n = 1'b0; i_id_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    for (int i = 0; i < 32; i++) rom[i] = NOP;
    rom[0] = 32'h0000_0013; rom[1] = 32'h0010_0093;
    rom[2] = 32'h0020_0113; rom[3] = 32'h0030_0193;
    rom[16] = 32'h0050_0293; rom[17] = 32'h0060_0313;
    model_reset();
    @(posedge i_clk);
    #1;

    // ---- Stream, stall, redirect: table-driven ----
    vt[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         32'h0,  32'd0};
    vt[1] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h0000_0013, 32'h4,  32'd0};
    vt[2] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0010_0093, 32'h8,  32'd1};
    vt[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0010_0093, 32'h8,  32'd1};
    vt[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0010_0093, 32'h8,  32'd1};
    vt[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h0010_0093, 32'h8,  32'd1};
    vt[6] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  32'h0020_0113, 32'hC,  32'd2};
    vt[7] = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h8,  32'h0020_0113, 32'h40, 32'd3};
    vt[8] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h0050_0293, 32'h44, 32'd3};
    vt[9] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 32'h0060_0313, 32'h48, 32'd4};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vt[i].rdy, vt[i].redir, vt[i].rpc);
      chk($sformatf("vec%0d.if_valid", i), {31'b0, o_if_valid}, {31'b0, vt[i].exp_valid});
      chk($sformatf("vec%0d.if_pc", i),    o_if_pc,       vt[i].exp_ifpc);
      chk($sformatf("vec%0d.if_instr", i), o_if_instr,    vt[i].exp_instr);
      chk($sformatf("vec%0d.imem_addr", i), o_imem_addr,  vt[i].exp_addr);
      chk($sformatf("vec%0d.count", i),    o_fetch_count, vt[i].exp_count);
    end

    // ---- Async reset mid-stream (o_if_valid=1 here), then refetch from RESET_PC ----
    chk("pre_rst.if_valid", {31'b0, o_if_valid}, 32'd1);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    chk("post_rst.E0.if_valid", {31'b0, o_if_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("post_rst.E1.if_valid", {31'b0, o_if_valid}, 32'd1);
    chk("post_rst.E1.if_pc", o_if_pc, 32'h0);

    // ---- EBREAK at word 5 ----
    for (int i = 0; i < 32; i++) rom[i] = NOP;
    rom[5] = EBREAK;
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h0);
    chk("ebreak.if_pc",     o_if_pc, 32'h14);
    chk("ebreak.if_instr",  o_if_instr, EBREAK);
    chk("ebreak.halted",    {31'b0, o_halted}, 32'd1);
    chk("ebreak.imem_addr", o_imem_addr, 32'h18);
    step(1'b0, 1'b0, 32'h0);
    chk("ebreak.held_valid", {31'b0, o_if_valid}, 32'd1);
    step(1'b1, 1'b0, 32'h0);
    chk("ebreak.drained", {31'b0, o_if_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("ebreak.no_load", {31'b0, o_if_valid}, 32'd0);
    chk("ebreak.addr_frozen", o_imem_addr, 32'h18);
    step(1'b1, 1'b1, 32'h0);
    chk("ebreak.resume_halted", {31'b0, o_halted}, 32'd0);
    chk("ebreak.resume_addr", o_imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("ebreak.resume_pc", o_if_pc, 32'h0);
    chk("ebreak.resume_valid", {31'b0, o_if_valid}, 32'd1);

    // ---- Fault: misaligned redirect ----
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h42);
    chk("misalign.fault",    {31'b0, o_fault},    32'd1);
    chk("misalign.halted",   {31'b0, o_halted},   32'd1);
    chk("misalign.if_valid", {31'b0, o_if_valid}, 32'd0);
    step(1'b1, 1'b1, 32'h0);
    chk("misalign.redir_halted", {31'b0, o_halted}, 32'd1);
    step(1'b1, 1'b0, 32'h0);
    chk("misalign.stays_empty", {31'b0, o_if_valid}, 32'd0);

    // ---- Fault: sequential fetch runs off the end of the ROM ----
    for (int i = 0; i < 32; i++) rom[i] = NOP;
    do_reset();
    for (int i = 0; i < 34; i++) step(1'b1, 1'b0, 32'h0);
    chk("range.fault",    {31'b0, o_fault},    32'd1);
    chk("range.halted",   {31'b0, o_halted},   32'd1);
    chk("range.if_valid", {31'b0, o_if_valid}, 32'd0);
    chk("range.last_pc",  o_if_pc, 32'h7C);
    chk("range.count",    o_fetch_count, 32'd32);
    step(1'b1, 1'b1, 32'h0);
    chk("range.redir_halted", {31'b0, o_halted}, 32'd1);

    // ---- Randomized run against the model ----
    for (int i = 0; i < 32; i++)
      rom[i] = ($urandom_range(0, 15) == 0) ? EBREAK : $urandom;
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      logic        rdy, redir;
      logic [31:0] rpc;
      int          kind;
      if (n % 200 == 199) begin
        do_reset();
      end
      rdy   = $urandom_range(0, 3) != 0;
      redir = $urandom_range(0, 11) == 0;
      kind  = $urandom_range(0, 9);
      if (kind < 7)      rpc = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      else if (kind < 9) rpc = {24'd0, 6'($urandom_range(28, 40)), 2'b00};
      else               rpc = $urandom;
      step(rdy, redir, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
